// File: rtl/timing_gen.sv
// Beat sequencer producing the w1/w2/w3 timing beats for the hardwired controller,
// with a synchronized start button and a completed-instruction-cycle counter.
module timing_gen #(
    parameter int CYC_W = 8
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CYC_W-1:0] cyc_cnt
);

    typedef enum logic [1:0] {IDLE, W1, W2, W3} state_t;

    state_t state, state_nxt;
    logic   q1, q2, q3;
    logic   start;
    logic   cyc_end;

    // qd is asynchronous: two flops to settle it, a third to find its rising edge.
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge t3 or negedge clr) begin
        if (!clr) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
            q3 <= 1'b0;
        end else begin
            q1 <= qd;
            q2 <= q1;
            q3 <= q2;
        end
    end

    assign start = q2 & ~q3;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cyc_end   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = W1;
            W1: begin
                if (stop) begin
                    state_nxt = IDLE;
                    cyc_end   = 1'b1;
                end else if (short) begin
                    state_nxt = W1;
                    cyc_end   = 1'b1;
                end else begin
                    state_nxt = W2;
                end
            end
            W2: begin
                if (stop) begin
                    state_nxt = IDLE;
                    cyc_end   = 1'b1;
                end else if (long) begin
                    state_nxt = W3;
                end else begin
                    state_nxt = W1;
                    cyc_end   = 1'b1;
                end
            end
            W3: begin
                state_nxt = stop ? IDLE : W1;
                cyc_end   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat outputs are registered from the next state so they change cleanly on t3.
    always_ff @(posedge t3 or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            w1      <= 1'b0;
            w2      <= 1'b0;
            w3      <= 1'b0;
            running <= 1'b0;
            cyc_cnt <= '0;
        end else begin
            state   <= state_nxt;
            w1      <= (state_nxt == W1);
            w2      <= (state_nxt == W2);
            w3      <= (state_nxt == W3);
            running <= (state_nxt != IDLE);
            if (cyc_end) cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
    end

endmodule
